writeback: RTL and testbench
============================

# writeback

Register-file writeback stage of the front-end pipeline: the consuming end of the result interface that `execute` drives, and the producer of the operand data that `execute` reads. It buffers completed results in a small FIFO and drains them into the architectural general-purpose register file one per cycle, honouring x86 partial-width writes. It also serves execute's two operand read ports and flags read-after-write hazards against results that are still buffered.

## Interface
- BIT_WIDTH, 32, register width.
- REG_COUNT, 8, number of general-purpose registers (EAX..EDI).
- FIFO_DEPTH, 2, result buffer entries (power of two, ≥2).
- IDX_W, $clog2(REG_COUNT), register index width (derived, not overridden).

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- result_valid  input  1  execute presents a result.
- result_ready  output  1  FIFO can accept (count < FIFO_DEPTH).
- register_index_result  input  IDX_W  destination register.
- register_data_result  input  BIT_WIDTH  result value, right-aligned.
- result_size  input  2  0=byte low [7:0], 1=byte high [15:8], 2=word [15:0], 3=dword [31:0].
- write_stall  input  1  register file write port blocked this cycle.
- register_index_operand_1 / _2  input  IDX_W  read addresses.
- register_data_operand_1 / _2  output  BIT_WIDTH  architectural register contents.
- operand_hazard_1 / _2  output  1  a buffered entry targets that index.
- retired_count  output  32  count of results written to the register file.

## Operation
- Handshake: transfer when result_valid && result_ready at a rising edge; index, data and size captured together. result_ready depends only on FIFO count (no combinational path from write_stall or result_valid).
- FIFO: in-order, head drains when not empty and write_stall=0.
- Drain merge on register r = entry index, d = entry data:
  - size 0: r[7:0] <= d[7:0]; other bits kept.
  - size 1: r[15:8] <= d[7:0]; other bits kept.
  - size 2: r[15:0] <= d[15:0]; r[31:16] kept.
  - size 3: r <= d.
- Each drain increments retired_count by 1; wraps 0xFFFF_FFFF -> 0.
- Read ports combinational from the register array only (no bypass); both ports may address the same register.
- operand_hazard_k = OR over valid FIFO entries of (entry index == register_index_operand_k). An entry being drained this cycle still counts. An incoming (not yet captured) result does not.
- Execute must not consume operand data while its hazard is 1.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): all registers 0, FIFO empty, retired_count 0, result_ready 1, operand_hazard_1/2 0, register_data_operand_1/2 0.
- Accept at edge N -> entry visible (hazard asserted) after N -> earliest drain at edge N+1 -> new value on read port and hazard cleared after N+1. Minimum latency two edges, accept to visible.
- Throughput: one result per cycle sustained while write_stall=0.
- Simultaneous push and pop: count unchanged, order preserved. When full, push is impossible (ready=0) even if a pop occurs that cycle.
- write_stall=1: no drain, no retire increment, FIFO holds. With count == FIFO_DEPTH, result_ready=0 until the next drain edge.
- Two buffered entries to the same register drain in order. The final value is the merge of both.
- Reset mid-operation: buffered entries are discarded without writing, and retired_count is not incremented.

## Test plan
- Reset, then accept EAX(idx 0)=0x1234_5678 size 3 -> hazard_1 (idx 0) high for one cycle; after two edges operand_1 reads 0x1234_5678, retired_count=1.
- EAX=0xAABB_CCDD preloaded, then size 1 data 0x0000_0011 -> EAX=0xAABB_11DD. Then size 0 data 0x22 -> 0xAABB_1122. Then size 2 data 0x3344 -> 0xAABB_3344.
- write_stall held high, three back-to-back valids -> first two accepted, result_ready=0 on the third. Release stall -> drains on consecutive edges, third accepted the cycle after the first drain.
- Continuous valid with stall=0 for 100 results to rotating indices -> one accept per cycle, retired_count=100, final register values match a reference model.
- Two buffered writes to ECX (size 3 0x1, then size 0 0xFF) -> ECX=0x0000_00FF; hazard stays high until the second drains.
- rst_n pulsed low with two entries buffered -> registers 0, retired_count 0, result_ready 1 immediately (asynchronous), no writes after release.

Source files
------------

// File: rtl/writeback.sv
// Register-file writeback stage: buffers execute results in a small in-order
// FIFO, drains one per cycle into the GPR file with x86 partial-width merge,
// serves two combinational operand read ports and flags RAW hazards against
// results that are still buffered.
module writeback #(
    parameter  int BIT_WIDTH  = 32,
    parameter  int REG_COUNT  = 8,
    parameter  int FIFO_DEPTH = 2,
    localparam int IDX_W      = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 result_valid,
    output logic                 result_ready,
    input  logic [IDX_W-1:0]     register_index_result,
    input  logic [BIT_WIDTH-1:0] register_data_result,
    input  logic [1:0]           result_size,
    input  logic                 write_stall,
    input  logic [IDX_W-1:0]     register_index_operand_1,
    input  logic [IDX_W-1:0]     register_index_operand_2,
    output logic [BIT_WIDTH-1:0] register_data_operand_1,
    output logic [BIT_WIDTH-1:0] register_data_operand_2,
    output logic                 operand_hazard_1,
    output logic                 operand_hazard_2,
    output logic [31:0]          retired_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Which slice of the destination register a result overwrites.
    typedef enum logic [1:0] {
        SIZE_BYTE_LO = 2'd0,
        SIZE_BYTE_HI = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_DWORD   = 2'd3
    } size_e;

    // Result buffer: payload slots plus per-slot valid bits for hazard lookup.
    logic [IDX_W-1:0]     fifo_idx_q  [FIFO_DEPTH];
    logic [BIT_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    size_e                fifo_size_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_valid_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    // Architectural register file and retirement counter.
    logic [BIT_WIDTH-1:0] regs_q [REG_COUNT];
    logic [31:0]          retired_count_q;

    logic                 push;
    logic                 pop;
    logic [IDX_W-1:0]     head_idx;
    logic [BIT_WIDTH-1:0] head_data;
    size_e                head_size;
    logic [BIT_WIDTH-1:0] merged_d;

    // Ready depends on occupancy only, so a full buffer refuses a push even
    // when the head drains in the same cycle.
    assign result_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign push         = result_valid && result_ready;
    assign pop          = (count_q != '0) && !write_stall;

    assign head_idx  = fifo_idx_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];
    assign head_size = fifo_size_q[rd_ptr_q];

    // Merge the head entry into the current contents of its destination.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        merged_d = regs_q[head_idx];
        unique case (head_size)
            SIZE_BYTE_LO: merged_d[7:0]  = head_data[7:0];
            SIZE_BYTE_HI: merged_d[15:8] = head_data[7:0];
            SIZE_WORD:    merged_d[15:0] = head_data[15:0];
            default:      merged_d       = head_data;
        endcase
    end

    // Hazard lookup: any buffered entry (including the one draining now)
    // that targets the requested index.
    always_comb begin
        operand_hazard_1 = 1'b0;
        operand_hazard_2 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_valid_q[i] && (fifo_idx_q[i] == register_index_operand_1))
                operand_hazard_1 = 1'b1;
            if (fifo_valid_q[i] && (fifo_idx_q[i] == register_index_operand_2))
                operand_hazard_2 = 1'b1;
        end
    end

    // Read ports come straight from the architectural array, no bypass.
    assign register_data_operand_1 = regs_q[register_index_operand_1];
    assign register_data_operand_2 = regs_q[register_index_operand_2];
    assign retired_count           = retired_count_q;

    // FIFO control: pointers, occupancy and slot valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fifo_valid_q <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q               <= rd_ptr_q + PTR_W'(1);
                fifo_valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push) begin
                wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
                fifo_valid_q[wr_ptr_q] <= 1'b1;
            end
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push)
                count_q <= count_q - CNT_W'(1);
        end
    end

    // FIFO payload capture on an accepted handshake.
    always_ff @(posedge clk) begin
        // NOTE: payload slots are not reset; the reset valid bits and count
        // guarantee a stale slot is never drained or matched.
        if (push) begin
            fifo_idx_q[wr_ptr_q]  <= register_index_result;
            fifo_data_q[wr_ptr_q] <= register_data_result;
            fifo_size_q[wr_ptr_q] <= size_e'(result_size);
        end
    end

    // Register file: cleared on reset, head entry merged in on each drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < REG_COUNT; r++) regs_q[r] <= '0;
        end else if (pop) begin
            regs_q[head_idx] <= merged_d;
        end
    end

    // Retirement counter, one per drain, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired_count_q <= '0;
        else if (pop)
            retired_count_q <= retired_count_q + 32'd1;
    end

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback with a FIFO-order scoreboard and a reference
// register model updated when the scoreboard predicts a drain.
module tb_writeback;

    localparam int BW = 32;
    localparam int RC = 8;
    localparam int FD = 2;
    localparam int IW = 3;

    logic          clk;
    logic          rst_n;
    logic          result_valid;
    logic          result_ready;
    logic [IW-1:0] register_index_result;
    logic [BW-1:0] register_data_result;
    logic [1:0]    result_size;
    logic          write_stall;
    logic [IW-1:0] register_index_operand_1;
    logic [IW-1:0] register_index_operand_2;
    logic [BW-1:0] register_data_operand_1;
    logic [BW-1:0] register_data_operand_2;
    logic          operand_hazard_1;
    logic          operand_hazard_2;
    logic [31:0]   retired_count;

    writeback #(
        .BIT_WIDTH (BW),
        .REG_COUNT (RC),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .result_valid            (result_valid),
        .result_ready            (result_ready),
        .register_index_result   (register_index_result),
        .register_data_result    (register_data_result),
        .result_size             (result_size),
        .write_stall             (write_stall),
        .register_index_operand_1(register_index_operand_1),
        .register_index_operand_2(register_index_operand_2),
        .register_data_operand_1 (register_data_operand_1),
        .register_data_operand_2 (register_data_operand_2),
        .operand_hazard_1        (operand_hazard_1),
        .operand_hazard_2        (operand_hazard_2),
        .retired_count           (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] idx;
        logic [BW-1:0] data;
        logic [1:0]    size;
    } entry_t;

    entry_t        sb[$];
    logic [BW-1:0] arch [RC];
    logic [31:0]   exp_retired;
    bit            last_acc;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_merge(logic [31:0] old, logic [31:0] d, logic [1:0] sz);
        case (sz)
            2'd0:    return {old[31:8], d[7:0]};
            2'd1:    return {old[31:16], d[7:0], old[7:0]};
            2'd2:    return {old[31:16], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic bit model_hazard(logic [IW-1:0] ix);
        foreach (sb[i]) if (sb[i].idx == ix) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        sb.delete();
        for (int r = 0; r < RC; r++) arch[r] = '0;
        exp_retired = 0;
    endtask

    // One clock edge: predict accept/drain from the model, then compare.
    task automatic tick();
        bit     acc;
        bit     drn;
        entry_t inc;
        entry_t e;
        check("ready_pre", result_ready, (sb.size() < FD));
        acc = result_valid && (sb.size() < FD);
        drn = (sb.size() != 0) && !write_stall;
        inc = '{idx: register_index_result, data: register_data_result, size: result_size};
        @(posedge clk);
        #1;
        if (drn) begin
            e = sb.pop_front();
            arch[e.idx] = ref_merge(arch[e.idx], e.data, e.size);
            exp_retired++;
        end
        if (acc) sb.push_back(inc);
        last_acc = acc;
        check("retired", retired_count, exp_retired);
        check("hazard_1", operand_hazard_1, model_hazard(register_index_operand_1));
        check("operand_1", register_data_operand_1, arch[register_index_operand_1]);
        if (drn) begin
            register_index_operand_2 = e.idx;
            #1;
            check("drain_operand_2", register_data_operand_2, arch[e.idx]);
            check("hazard_2", operand_hazard_2, model_hazard(e.idx));
        end
    endtask

    task automatic drive(input logic [IW-1:0] ix, input logic [BW-1:0] d, input logic [1:0] sz);
        result_valid          = 1'b1;
        register_index_result = ix;
        register_data_result  = d;
        result_size           = sz;
    endtask

    // Present one result until accepted (bounded), then drop valid.
    task automatic send(input logic [IW-1:0] ix, input logic [BW-1:0] d, input logic [1:0] sz);
        drive(ix, d, sz);
        last_acc = 1'b0;
        for (int k = 0; k < 8 && !last_acc; k++) tick();
        check("send_accept", last_acc, 1);
        result_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] base;

        rst_n                    = 1'b0;
        result_valid             = 1'b0;
        register_index_result    = '0;
        register_data_result     = '0;
        result_size              = 2'd0;
        write_stall              = 1'b0;
        register_index_operand_1 = '0;
        register_index_operand_2 = '0;
        model_clear();

        // Reset state.
        @(posedge clk);
        #1;
        check("rst_ready", result_ready, 1);
        check("rst_retired", retired_count, 0);
        check("rst_hazard_1", operand_hazard_1, 0);
        check("rst_hazard_2", operand_hazard_2, 0);
        check("rst_operand_1", register_data_operand_1, 0);
        check("rst_operand_2", register_data_operand_2, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Single dword to EAX: hazard for one cycle, visible after two edges.
        register_index_operand_1 = 3'd0;
        send(3'd0, 32'h1234_5678, 2'd3);
        check("t1_hazard_up", operand_hazard_1, 1);
        check("t1_not_yet", register_data_operand_1, 0);
        tick();
        check("t1_hazard_down", operand_hazard_1, 0);
        check("t1_value", register_data_operand_1, 32'h1234_5678);
        check("t1_retired", retired_count, 1);

        // Partial-width merges on EAX.
        send(3'd0, 32'hAABB_CCDD, 2'd3);
        tick();
        check("merge_preload", register_data_operand_1, 32'hAABB_CCDD);
        send(3'd0, 32'h0000_0011, 2'd1);
        tick();
        check("merge_byte_hi", register_data_operand_1, 32'hAABB_11DD);
        send(3'd0, 32'h0000_0022, 2'd0);
        tick();
        check("merge_byte_lo", register_data_operand_1, 32'hAABB_1122);
        send(3'd0, 32'h0000_3344, 2'd2);
        tick();
        check("merge_word", register_data_operand_1, 32'hAABB_3344);

        // Stall with three back-to-back results.
        base = exp_retired;
        write_stall = 1'b1;
        drive(3'd3, 32'h0000_0333, 2'd3);
        tick();
        check("stall_acc1", last_acc, 1);
        drive(3'd4, 32'h0000_0444, 2'd3);
        tick();
        check("stall_acc2", last_acc, 1);
        drive(3'd5, 32'h0000_0555, 2'd3);
        check("stall_full_ready", result_ready, 0);
        tick();
        check("stall_hold_retired", retired_count, base);
        write_stall = 1'b0;
        tick();
        check("stall_first_drain", retired_count, base + 1);
        check("stall_ready_back", result_ready, 1);
        tick();
        check("stall_third_acc", last_acc, 1);
        result_valid = 1'b0;
        tick();
        check("stall_all_drained", retired_count, base + 3);
        register_index_operand_1 = 3'd5;
        #1;
        check("stall_third_value", register_data_operand_1, 32'h0000_0555);

        // Sustained stream: one accept per cycle, 100 results.
        base = exp_retired;
        for (int i = 0; i < 100; i++) begin
            register_index_operand_1 = IW'((i + 3) % RC);
            drive(IW'(i % RC), $urandom, 2'(i % 4));
            tick();
            check("stream_accept", last_acc, 1);
        end
        result_valid = 1'b0;
        tick();
        tick();
        check("stream_retired", retired_count, base + 100);
        @(negedge clk);
        for (int r = 0; r < RC; r++) begin
            register_index_operand_1 = IW'(r);
            #1;
            check("stream_final_reg", register_data_operand_1, arch[r]);
        end

        // Two buffered writes to ECX drain in order and merge.
        register_index_operand_1 = 3'd1;
        write_stall = 1'b1;
        send(3'd1, 32'h0000_0001, 2'd3);
        send(3'd1, 32'h0000_00FF, 2'd0);
        check("ecx_hazard_buffered", operand_hazard_1, 1);
        write_stall = 1'b0;
        tick();
        check("ecx_hazard_after_first", operand_hazard_1, 1);
        check("ecx_after_first", register_data_operand_1, 32'h0000_0001);
        tick();
        check("ecx_hazard_cleared", operand_hazard_1, 0);
        check("ecx_final", register_data_operand_1, 32'h0000_00FF);

        // Asynchronous reset with two entries buffered.
        send(3'd6, 32'h55AA_55AA, 2'd3);
        tick();
        register_index_operand_1 = 3'd6;
        #1;
        check("pre_reset_reg6", register_data_operand_1, 32'h55AA_55AA);
        write_stall = 1'b1;
        send(3'd6, 32'hDEAD_BEEF, 2'd3);
        send(3'd7, 32'hCAFE_F00D, 2'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("async_rst_ready", result_ready, 1);
        check("async_rst_retired", retired_count, 0);
        check("async_rst_reg6", register_data_operand_1, 0);
        check("async_rst_hazard_1", operand_hazard_1, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        write_stall = 1'b0;
        #1;
        tick();
        tick();
        tick();
        check("post_rst_retired", retired_count, 0);
        check("post_rst_reg6", register_data_operand_1, 0);
        register_index_operand_1 = 3'd7;
        #1;
        check("post_rst_reg7", register_data_operand_1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
